// File: rtl/cpu_data_ram.sv
// cpu_data_ram: single-port synchronous data RAM behind a valid/ready request
// interface. Per-byte write strobes, read latency of 1 or 2 cycles, optional
// post-reset sweep of the whole array, and out-of-range access flagging.
module cpu_data_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int SIZE = 1024,
  parameter int ADDR_WIDTH = $clog2(SIZE),
  parameter int READ_LATENCY = 1,
  parameter int CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_data,
  output logic                    resp_err,
  output logic                    wr_err,
  output logic                    busy
);

  localparam int NB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0]   SIZE_X    = (ADDR_WIDTH + 1)'(SIZE);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SIZE - 1);

  typedef enum logic {S_CLEAR, S_READY} state_t;

  localparam state_t S_RESET = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;

  // Address check against the true array depth (SIZE need not be 2**ADDR_WIDTH).
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} < SIZE_X);
  endfunction

  // Reads that were out of range, and the idle state after reset, present zero.
  function automatic logic [DATA_WIDTH-1:0] mask_data(input logic zero,
                                                      input logic [DATA_WIDTH-1:0] d);
    return zero ? '0 : d;
  endfunction

  logic [DATA_WIDTH-1:0] r_mem [SIZE];

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_clr_cnt;
  logic                  r_ready;
  logic                  r_wr_err;

  logic                  w_accept;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_in_range;
  logic                  w_rd_en;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [NB-1:0]         w_mem_be;
  logic [DATA_WIDTH-1:0] w_mem_wdata;

  // stage p1 state: array output register plus its control
  logic                  r_vld_p1;
  logic                  r_err_p1;
  logic [DATA_WIDTH-1:0] r_rdata_p1;
  logic [DATA_WIDTH-1:0] w_data_p1;

  assign w_accept   = req_valid & r_ready;
  assign w_wr_acc   = w_accept & req_write;
  assign w_rd_acc   = w_accept & ~req_write;
  assign w_in_range = in_range(req_addr);

  assign req_ready = r_ready;
  assign busy      = (r_state == S_CLEAR);
  assign wr_err    = r_wr_err;

  // Next-state: the sweep leaves CLEAR right after writing the last word.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_CLEAR: if (r_clr_cnt == LAST_ADDR) w_state_nxt = S_READY;
      S_READY: w_state_nxt = S_READY;
      default: w_state_nxt = S_RESET;
    endcase
  end

  // Single array port shared by the sweep and the request path.
  always_comb begin
    w_mem_addr  = req_addr;
    w_mem_be    = '0;
    w_mem_wdata = req_wdata;
    w_rd_en     = 1'b0;
    if (r_state == S_CLEAR) begin
      w_mem_addr  = r_clr_cnt;
      w_mem_be    = '1;
      w_mem_wdata = CLEAR_VALUE;
    end else begin
      if (w_wr_acc && w_in_range) w_mem_be = req_be;
      w_rd_en = w_rd_acc & w_in_range;
    end
  end

  // Control registers: FSM, sweep counter, ready, error pulses, p1 valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_RESET;
      r_clr_cnt <= '0;
      r_ready   <= 1'b0;
      r_wr_err  <= 1'b0;
      r_vld_p1  <= 1'b0;
      // Set so that resp_data reads as zero until the first read returns.
      r_err_p1  <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_ready   <= (w_state_nxt == S_READY);
      r_clr_cnt <= (r_state == S_CLEAR) ? r_clr_cnt + 1'b1 : '0;
      r_wr_err  <= w_wr_acc & ~w_in_range;
      r_vld_p1  <= w_rd_acc;
      if (w_rd_acc) r_err_p1 <= ~w_in_range;
    end
  end

  // Block RAM: byte-masked write and read-first output register, no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (w_mem_be[i]) r_mem[w_mem_addr][i*8 +: 8] <= w_mem_wdata[i*8 +: 8];
    end
    if (w_rd_en) r_rdata_p1 <= r_mem[w_mem_addr];
  end

  // ---- stage p1 -> output ----
  assign w_data_p1 = mask_data(r_err_p1, r_rdata_p1);

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  r_vld_p2;
      logic                  r_err_p2;
      logic [DATA_WIDTH-1:0] r_data_p2;

      // ---- stage p2: extra output register ----
      // Extra output register; data only advances with a valid response so it holds.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_vld_p2  <= 1'b0;
          r_err_p2  <= 1'b0;
          r_data_p2 <= '0;
        end else begin
          r_vld_p2 <= r_vld_p1;
          if (r_vld_p1) begin
            r_err_p2  <= r_err_p1;
            r_data_p2 <= w_data_p1;
          end
        end
      end

      assign resp_valid = r_vld_p2;
      assign resp_err   = r_vld_p2 & r_err_p2;
      assign resp_data  = r_data_p2;
    end else begin : g_lat1
      assign resp_valid = r_vld_p1;
      assign resp_err   = r_vld_p1 & r_err_p1;
      assign resp_data  = w_data_p1;
    end
  endgenerate

endmodule
